// File: rtl/alu_mp_seq_if.sv
// Bus bundle between the multi-precision sequencer, its controller, the
// operand/result store and the shared 16-bit ALU.
interface alu_mp_seq_if;
   logic        start;
   logic        op;
   logic [3:0]  len;
   logic        abort;
   logic        busy;
   logic        done;
   logic [3:0]  rd_addr;
   logic [15:0] rd_a;
   logic [15:0] rd_b;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [1:0]  alu_sel;
   logic        alu_cin;
   logic [15:0] alu_sum;
   logic        alu_c;
   logic        alu_z;
   logic        alu_n;
   logic        alu_v;
   logic        flag_c;
   logic        flag_z;
   logic        flag_n;
   logic        flag_v;

   modport slave (
      input  start, op, len, abort, rd_a, rd_b,
             alu_sum, alu_c, alu_z, alu_n, alu_v,
      output busy, done, rd_addr, wr_en, wr_addr, wr_data,
             alu_a, alu_b, alu_sel, alu_cin,
             flag_c, flag_z, flag_n, flag_v
   );

   modport master (
      output start, op, len, abort, rd_a, rd_b,
             alu_sum, alu_c, alu_z, alu_n, alu_v,
      input  busy, done, rd_addr, wr_en, wr_addr, wr_data,
             alu_a, alu_b, alu_sel, alu_cin,
             flag_c, flag_z, flag_n, flag_v
   );
endinterface

// File: rtl/alu_mp_seq.sv
// Multi-precision add/subtract sequencer: chains the shared 16-bit ALU across
// up to WORDS little-endian words and accumulates full-width N/Z/C/V flags.
module alu_mp_seq #(
   parameter int WORDS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_mp_seq_if.slave bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

   localparam logic [3:0] LMAX = 4'(WORDS - 1);

   state_t      state, state_nxt;
   logic        op_r;
   logic [3:0]  lim;
   logic [3:0]  idx;
   logic        cr, cr_nxt;
   logic        zacc, zacc_nxt;
   logic        last;
   logic [3:0]  flags_prev;

   function automatic logic [3:0] clamp_len(input logic [3:0] l);
      return (l > LMAX) ? LMAX : l;
   endfunction

   assign bus.alu_a = bus.rd_a;
   assign bus.alu_b = bus.rd_b;

   always_comb begin
      state_nxt   = state;
      bus.busy    = 1'b0;
      bus.done    = 1'b0;
      bus.rd_addr = 4'd0;
      bus.alu_sel = 2'b00;
      bus.alu_cin = 1'b0;
      cr_nxt      = cr;
      zacc_nxt    = zacc;
      last        = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) state_nxt = RUN;
         end
         RUN: begin
            bus.busy    = 1'b1;
            bus.rd_addr = idx;
            bus.alu_sel = {op_r, (idx != 4'd0)};
            bus.alu_cin = cr;
            // The chain register holds a borrow when subtracting; SBB inverts Cin.
            cr_nxt      = op_r ? ~bus.alu_c : bus.alu_c;
            zacc_nxt    = ((idx == 4'd0) ? 1'b1 : zacc) & bus.alu_z;
            last        = (idx == lim);
            if (bus.abort)  state_nxt = IDLE;
            else if (last)  state_nxt = FIN;
         end
         FIN: begin
            bus.busy  = 1'b1;
            bus.done  = ~bus.abort;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         op_r        <= 1'b0;
         lim         <= 4'd0;
         idx         <= 4'd0;
         cr          <= 1'b0;
         zacc        <= 1'b0;
         flags_prev  <= 4'd0;
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= 4'd0;
         bus.wr_data <= 16'd0;
         bus.flag_c  <= 1'b0;
         bus.flag_z  <= 1'b0;
         bus.flag_n  <= 1'b0;
         bus.flag_v  <= 1'b0;
      end else begin
         state     <= state_nxt;
         bus.wr_en <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_r <= bus.op;
                  lim  <= clamp_len(bus.len);
                  idx  <= 4'd0;
                  cr   <= 1'b0;
               end
            end
            RUN: begin
               cr          <= cr_nxt;
               zacc        <= zacc_nxt;
               bus.wr_en   <= ~bus.abort;
               bus.wr_addr <= idx;
               bus.wr_data <= bus.alu_sum;
               if (!last) idx <= idx + 4'd1;
               // Old flags are kept aside so an abort during FIN can restore them.
               if (last && !bus.abort) begin
                  flags_prev <= {bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v};
                  bus.flag_c <= cr_nxt;
                  bus.flag_z <= zacc_nxt;
                  bus.flag_n <= bus.alu_n;
                  bus.flag_v <= bus.alu_v;
               end
            end
            FIN: begin
               if (bus.abort) begin
                  bus.flag_c <= flags_prev[3];
                  bus.flag_z <= flags_prev[2];
                  bus.flag_n <= flags_prev[1];
                  bus.flag_v <= flags_prev[0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mp_seq.sv
// Scoreboard bench for alu_mp_seq: wide-integer reference model, an ALU and
// operand-store model, and a negedge monitor that pops expected events.
module tb_alu_mp_seq;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   cyc = 0;
   int   npass = 0;
   int   ntot = 0;

   alu_mp_seq_if bif ();

   alu_mp_seq #(.WORDS(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] mem_a [16];
   logic [15:0] mem_b [16];
   assign bif.rd_a = mem_a[bif.rd_addr];
   assign bif.rd_b = mem_b[bif.rd_addr];

   // Shared ALU: 00 ADD, 01 ADC, 10 SUB, 11 SBB (SBB takes an inverted Cin).
   logic [16:0] alu_s;
   logic [15:0] alu_bb;
   logic        alu_ci;
   always_comb begin
      alu_bb = bif.alu_sel[1] ? ~bif.alu_b : bif.alu_b;
      case (bif.alu_sel)
         2'b00:   alu_ci = 1'b0;
         2'b01:   alu_ci = bif.alu_cin;
         2'b10:   alu_ci = 1'b1;
         default: alu_ci = ~bif.alu_cin;
      endcase
      alu_s       = {1'b0, bif.alu_a} + {1'b0, alu_bb} + {16'd0, alu_ci};
      bif.alu_sum = alu_s[15:0];
      bif.alu_c   = alu_s[16];
      bif.alu_z   = (alu_s[15:0] == 16'd0);
      bif.alu_n   = alu_s[15];
      bif.alu_v   = (bif.alu_a[15] == alu_bb[15]) && (alu_s[15] != bif.alu_a[15]);
   end

   typedef struct packed { logic [3:0] addr; logic [15:0] data; } wr_t;
   typedef struct packed { logic [3:0] addr; logic [1:0] sel; logic cin; } sel_t;
   typedef struct packed { logic [3:0] flags; logic [31:0] cyc; } fin_t;

   wr_t  wq[$];
   sel_t sq[$];
   fin_t fq[$];

   logic [3:0] m_flags;
   logic [3:0] last_flags = 4'd0;
   logic       m_ok;
   int         m_l;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      ntot++;
      if (got === exp) npass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, got, exp, cyc);
   endtask

   // Reference: treat the operands as (L+1)*16-bit integers and do plain arithmetic.
   task automatic model(input logic o, input logic [3:0] ln, input int ab);
      logic [271:0] wa, wb, r, mk, t;
      int bits, nw, ns;
      m_l = (int'(ln) > W - 1) ? W - 1 : int'(ln);
      wa = '0;
      wb = '0;
      for (int k = 0; k <= m_l; k++) begin
         wa[16*k +: 16] = mem_a[k];
         wb[16*k +: 16] = mem_b[k];
      end
      bits = 16 * (m_l + 1);
      mk   = (272'(1) << bits) - 272'(1);
      r    = o ? (wa - wb) : (wa + wb);
      m_ok = !(ab >= 0 && ab <= m_l);
      nw   = m_ok ? m_l + 1 : ab;
      ns   = m_ok ? m_l : ab;
      for (int k = 0; k < nw; k++) wq.push_back('{addr: 4'(k), data: r[16*k +: 16]});
      for (int k = 0; k <= ns; k++) begin
         sel_t e;
         logic [271:0] mlo;
         mlo    = (272'(1) << (16 * k)) - 272'(1);
         t      = (wa & mlo) + (wb & mlo);
         e.addr = 4'(k);
         e.sel  = {o, (k != 0)};
         e.cin  = o ? ((wa & mlo) < (wb & mlo)) : t[16*k];
         sq.push_back(e);
      end
      m_flags[3] = o ? (wa < wb) : r[bits];
      m_flags[2] = ((r & mk) == '0);
      m_flags[1] = r[bits-1];
      m_flags[0] = o ? ((wa[bits-1] != wb[bits-1]) && (r[bits-1] != wa[bits-1]))
                     : ((wa[bits-1] == wb[bits-1]) && (r[bits-1] != wa[bits-1]));
   endtask

   task automatic set_ab(input logic [63:0] a, input logic [63:0] b);
      for (int k = 0; k < 16; k++) begin
         mem_a[k] = (k < 4) ? a[16*k +: 16] : 16'($urandom);
         mem_b[k] = (k < 4) ? b[16*k +: 16] : 16'($urandom);
      end
   endtask

   task automatic accept(input logic o, input logic [3:0] ln, input bit hold_start, output int t0);
      @(posedge clk); #1;
      bif.start = 1'b1;
      bif.op    = o;
      bif.len   = ln;
      @(posedge clk); #1;
      t0        = cyc;
      bif.start = hold_start;
      bif.op    = 1'($urandom);
      bif.len   = 4'($urandom);
   endtask

   task automatic run(input logic o, input logic [3:0] ln, input int ab, input bit pulse);
      int t0;
      model(o, ln, ab);
      accept(o, ln, pulse, t0);
      // done is sampled in the cycle that begins at edge T0+L+1.
      if (m_ok) fq.push_back('{flags: m_flags, cyc: 32'(t0 + m_l + 1)});
      if (pulse) begin
         @(posedge clk); #1;
         bif.start = 1'b0;
      end
      if (ab >= 0) begin
         repeat (ab) begin @(posedge clk); #1; end
         bif.abort = 1'b1;
         @(posedge clk); #1;
         bif.abort = 1'b0;
      end
      for (int n = 0; n < 40 && bif.busy; n++) begin @(posedge clk); #1; end
      check("busy_drop", {63'd0, bif.busy}, 64'd0);
      if (pulse) begin
         repeat (2) begin @(posedge clk); #1; end
         check("no_requeue", {63'd0, bif.busy}, 64'd0);
      end
      if (m_ok) last_flags = m_flags;
      else check("abort_flags", {60'd0, bif.flag_c, bif.flag_z, bif.flag_n, bif.flag_v},
                 {60'd0, last_flags});
      @(negedge clk);
      check("sb_empty", 64'(wq.size() + sq.size() + fq.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bif.busy && !bif.done) begin
            if (sq.size() == 0) check("word_unexp", {60'd0, bif.rd_addr}, 64'hFFFF);
            else begin
               sel_t e;
               e = sq.pop_front();
               check("rd_addr", {60'd0, bif.rd_addr}, {60'd0, e.addr});
               check("alu_sel_cin", {61'd0, bif.alu_sel, bif.alu_cin}, {61'd0, e.sel, e.cin});
            end
         end
         if (bif.wr_en) begin
            if (wq.size() == 0) check("wr_unexp", {60'd0, bif.wr_addr}, 64'hFFFF);
            else begin
               wr_t e;
               e = wq.pop_front();
               check("wr_word", {44'd0, bif.wr_addr, bif.wr_data}, {44'd0, e.addr, e.data});
            end
         end
         if (bif.done) begin
            if (fq.size() == 0) check("done_unexp", {63'd0, bif.done}, 64'd0);
            else begin
               fin_t e;
               e = fq.pop_front();
               check("flags_cnzv", {60'd0, bif.flag_c, bif.flag_z, bif.flag_n, bif.flag_v},
                     {60'd0, e.flags});
               check("done_cycle", 64'(cyc), {32'd0, e.cyc});
               check("done_with_wr", {63'd0, bif.wr_en}, 64'd1);
            end
         end
      end
   end

   function automatic logic [63:0] outs();
      return {30'd0, bif.busy, bif.done, bif.wr_en, bif.wr_addr, bif.wr_data, bif.rd_addr,
              bif.alu_sel, bif.alu_cin, bif.flag_c, bif.flag_z, bif.flag_n, bif.flag_v};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t0;
      bif.start = 1'b0;
      bif.op    = 1'b0;
      bif.len   = 4'd0;
      bif.abort = 1'b0;
      set_ab(64'd0, 64'd0);
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("reset_outs", outs(), 64'd0);
      rst_n = 1'b1;

      set_ab(64'h0000_0000_0001_FFFF, 64'h0000_0000_0000_0001);
      run(1'b0, 4'd1, -1, 1'b0);
      set_ab(64'h0, 64'h1);
      run(1'b1, 4'd1, -1, 1'b0);
      set_ab(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
      run(1'b1, 4'd3, -1, 1'b0);
      set_ab(64'h7FFF_FFFF, 64'h1);
      run(1'b0, 4'd1, -1, 1'b0);
      set_ab(64'hFFFF, 64'h1);
      run(1'b0, 4'd0, -1, 1'b0);
      set_ab(64'h0000_0000_0001_FFFF, 64'h0000_0000_0000_0001);
      run(1'b0, 4'd1, -1, 1'b1);
      set_ab({$urandom, $urandom}, {$urandom, $urandom});
      run(1'b0, 4'd15, -1, 1'b0);
      set_ab(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001);
      run(1'b0, 4'd3, 2, 1'b0);

      // Reset in the middle of a run, then a normal transaction.
      set_ab(64'h8000_0000_0000_0001, 64'h0000_0000_0000_0003);
      model(1'b0, 4'd3, -1);
      accept(1'b0, 4'd3, 1'b0, t0);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1 check("rst_midrun", outs(), 64'd0);
      wq.delete();
      sq.delete();
      fq.delete();
      last_flags = 4'd0;
      @(posedge clk); #1 rst_n = 1'b1;
      set_ab(64'h0000_0000_0001_FFFF, 64'h0000_0000_0000_0001);
      run(1'b0, 4'd1, -1, 1'b0);

      for (int it = 0; it < 24; it++) begin
         logic o;
         logic [3:0] ln;
         int mode;
         o    = 1'($urandom_range(0, 1));
         ln   = 4'($urandom_range(0, 15));
         mode = $urandom_range(0, 3);
         for (int k = 0; k < 16; k++) begin
            mem_a[k] = 16'($urandom);
            case (mode)
               1:       mem_b[k] = mem_a[k];
               2:       mem_b[k] = 16'hFFFF;
               default: mem_b[k] = 16'($urandom);
            endcase
         end
         run(o, ln, -1, 1'b0);
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
